// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit: the 2-bit op
// encodings seen on the execute-stage interface, the FSM state encoding and
// small helpers that decode an op into "is a divide" / "is signed".
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam logic [1:0] MULDIV_OP_MULT  = 2'b00;
    localparam logic [1:0] MULDIV_OP_MULTU = 2'b01;
    localparam logic [1:0] MULDIV_OP_DIV   = 2'b10;
    localparam logic [1:0] MULDIV_OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        MULDIV_ST_IDLE = 2'd0,
        MULDIV_ST_PRE  = 2'd1,
        MULDIV_ST_CALC = 2'd2,
        MULDIV_ST_POST = 2'd3
    } muldiv_state_e;

    // Bit 1 of the op selects divide, bit 0 selects the unsigned flavour.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// -----------------------------------------------------------------------------
// muldiv_signfix
// Combinational conditional two's-complement negate.
//   neg   in   1     1: dout = -din, 0: dout = din
//   din   in   XLEN  value to fix up
//   dout  out  XLEN  result
// -----------------------------------------------------------------------------
module muldiv_signfix #(
    parameter int XLEN = 32
) (
    input  logic            neg,
    input  logic [XLEN-1:0] din,
    output logic [XLEN-1:0] dout
);

    logic [XLEN-1:0] inv;

    // Conditional invert, then add the same control bit as the +1.
    genvar gi;
    generate
        for (gi = 0; gi < XLEN; gi++) begin : g_inv
            assign inv[gi] = din[gi] ^ neg;
        end
    endgenerate

    assign dout = inv + {{(XLEN-1){1'b0}}, neg};

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Multi-cycle iterative multiply/divide unit owning the HI/LO register pair.
// Sequence per op: IDLE -> PRE (operand magnitudes) -> CALC (XLEN iterations of
// shift-add or restoring divide) -> POST (sign fix-up, HI/LO write) -> IDLE.
// Accept edge T gives done high in cycle T+XLEN+2.
//   clk          in   1     clock
//   rst_n        in   1     asynchronous active-low reset
//   start        in   1     request strobe, honoured only when not busy
//   op           in   2     00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b         in   XLEN  rs / rt operands
//   hi_we, lo_we in   1     MTHI / MTLO write enables (ignored while busy)
//   wdata        in   XLEN  MTHI / MTLO data
//   busy         out  1     accept edge through done cycle inclusive
//   done         out  1     one-cycle pulse, HI/LO hold the new result
//   hi, lo       out  XLEN  HI / LO registers
// Optional build macro MULDIV_DIVZERO_FLAG_EN adds output div_by_zero: set in
// the done cycle of a divide with b==0, cleared on the next accepted start.
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            hi_we,
    input  logic            lo_we,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
`ifdef MULDIV_DIVZERO_FLAG_EN
    ,
    output logic            div_by_zero
`endif
);

    localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

    muldiv_state_e   state_reg, state_next;
    logic [1:0]      op_reg, op_next;
    logic [XLEN-1:0] a_reg, a_next;
    logic [XLEN-1:0] b_reg, b_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    // upper: partial product high half / partial remainder
    // lower: multiplier being consumed / dividend shifting out, quotient in
    // opnd : multiplicand / divisor magnitude
    logic [XLEN-1:0] upper_reg, upper_next;
    logic [XLEN-1:0] lower_reg, lower_next;
    logic [XLEN-1:0] opnd_reg, opnd_next;
    logic            res_neg_reg, res_neg_next;
    logic            rem_neg_reg, rem_neg_next;
    logic            done_reg, done_next;
    logic [XLEN-1:0] hi_reg, hi_next;
    logic [XLEN-1:0] lo_reg, lo_next;
`ifdef MULDIV_DIVZERO_FLAG_EN
    logic            dz_reg, dz_next;
`endif

    logic            is_div, is_signed;
    logic [XLEN-1:0] abs_a, abs_b, fix_lo, fix_hi;
    logic [XLEN:0]   shifted, diff, addend, sum;

    assign is_div    = op_is_div(op_reg);
    assign is_signed = op_is_signed(op_reg);

    muldiv_signfix #(.XLEN(XLEN)) u_abs_a (
        .neg (is_signed & a_reg[XLEN-1]), .din (a_reg), .dout (abs_a));
    muldiv_signfix #(.XLEN(XLEN)) u_abs_b (
        .neg (is_signed & b_reg[XLEN-1]), .din (b_reg), .dout (abs_b));
    muldiv_signfix #(.XLEN(XLEN)) u_fix_lo (
        .neg (res_neg_reg), .din (lower_reg), .dout (fix_lo));
    muldiv_signfix #(.XLEN(XLEN)) u_fix_hi (
        .neg (is_div ? rem_neg_reg : res_neg_reg), .din (upper_reg), .dout (fix_hi));

    // Restoring-divide trial subtract and shift-add partial sum.
    assign shifted = {upper_reg, lower_reg[XLEN-1]};
    assign diff    = shifted - {1'b0, opnd_reg};
    assign addend  = lower_reg[0] ? {1'b0, opnd_reg} : '0;
    assign sum     = {1'b0, upper_reg} + addend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= MULDIV_ST_IDLE;
            op_reg      <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            cnt_reg     <= '0;
            upper_reg   <= '0;
            lower_reg   <= '0;
            opnd_reg    <= '0;
            res_neg_reg <= 1'b0;
            rem_neg_reg <= 1'b0;
            done_reg    <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
`ifdef MULDIV_DIVZERO_FLAG_EN
            dz_reg      <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            op_reg      <= op_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            cnt_reg     <= cnt_next;
            upper_reg   <= upper_next;
            lower_reg   <= lower_next;
            opnd_reg    <= opnd_next;
            res_neg_reg <= res_neg_next;
            rem_neg_reg <= rem_neg_next;
            done_reg    <= done_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
`ifdef MULDIV_DIVZERO_FLAG_EN
            dz_reg      <= dz_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        op_next      = op_reg;
        a_next       = a_reg;
        b_next       = b_reg;
        cnt_next     = cnt_reg;
        upper_next   = upper_reg;
        lower_next   = lower_reg;
        opnd_next    = opnd_reg;
        res_neg_next = res_neg_reg;
        rem_neg_next = rem_neg_reg;
        done_next    = 1'b0;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
`ifdef MULDIV_DIVZERO_FLAG_EN
        dz_next      = dz_reg;
`endif
        case (state_reg)
            MULDIV_ST_IDLE: begin
                // The done cycle sits in IDLE but still reports busy, so
                // neither a new op nor an MTHI/MTLO is taken there.
                if (!done_reg) begin
                    if (hi_we) hi_next = wdata;
                    if (lo_we) lo_next = wdata;
                    if (start) begin
                        state_next = MULDIV_ST_PRE;
                        op_next    = op;
                        a_next     = a;
                        b_next     = b;
`ifdef MULDIV_DIVZERO_FLAG_EN
                        dz_next    = 1'b0;
`endif
                    end
                end
            end
            MULDIV_ST_PRE: begin
                opnd_next    = is_div ? abs_b : abs_a;
                lower_next   = is_div ? abs_a : abs_b;
                upper_next   = '0;
                res_neg_next = is_signed & (a_reg[XLEN-1] ^ b_reg[XLEN-1]);
                rem_neg_next = is_signed & a_reg[XLEN-1];
                cnt_next     = '0;
                state_next   = MULDIV_ST_CALC;
            end
            MULDIV_ST_CALC: begin
                if (is_div) begin
                    if (!diff[XLEN]) begin
                        upper_next = diff[XLEN-1:0];
                        lower_next = {lower_reg[XLEN-2:0], 1'b1};
                    end else begin
                        upper_next = shifted[XLEN-1:0];
                        lower_next = {lower_reg[XLEN-2:0], 1'b0};
                    end
                end else begin
                    upper_next = sum[XLEN:1];
                    lower_next = {sum[0], lower_reg[XLEN-1:1]};
                end
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == CW'(XLEN - 1)) state_next = MULDIV_ST_POST;
            end
            MULDIV_ST_POST: begin
                if (is_div && (b_reg == '0)) begin
                    hi_next = a_reg;
                    lo_next = '1;
                end else if (is_div) begin
                    hi_next = fix_hi;
                    lo_next = fix_lo;
                end else begin
                    // 2*XLEN negate: the borrow only reaches the high half
                    // when the low half is zero, otherwise it is a plain invert.
                    hi_next = (res_neg_reg && (lower_reg != '0)) ? ~upper_reg : fix_hi;
                    lo_next = fix_lo;
                end
`ifdef MULDIV_DIVZERO_FLAG_EN
                dz_next    = is_div && (b_reg == '0);
`endif
                done_next  = 1'b1;
                state_next = MULDIV_ST_IDLE;
            end
            default: state_next = MULDIV_ST_IDLE;
        endcase
    end

    assign busy = (state_reg != MULDIV_ST_IDLE) | done_reg;
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;
`ifdef MULDIV_DIVZERO_FLAG_EN
    assign div_by_zero = dz_reg;
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Self-checking bench for muldiv_unit (XLEN=32). A transaction-level model
// computes each result with plain 64-bit arithmetic and tracks busy/done/HI/LO
// timing; a compare loop checks every cycle, and directed cases pin both the
// model and the DUT to hand-computed literals. Build macro
// MULDIV_DIVZERO_FLAG_EN also checks the div_by_zero output.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_muldiv_unit;

    localparam int XLEN = 32;

    logic            clk, rst_n, start, hi_we, lo_we;
    logic [1:0]      op;
    logic [XLEN-1:0] a, b, wdata;
    logic            busy, done;
    logic [XLEN-1:0] hi, lo;
`ifdef MULDIV_DIVZERO_FLAG_EN
    logic            div_by_zero;
`endif

    int n_checks = 0;
    int n_errors = 0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
`ifdef MULDIV_DIVZERO_FLAG_EN
        ,
        .div_by_zero (div_by_zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference arithmetic ----------------
    function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sp;
        int     q, r;
        case (o)
            2'b00: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                return 64'(sp);
            end
            2'b01: return {32'd0, x} * {32'd0, y};
            2'b10: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
                return {r, q};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // ---------------- transaction-level timing model ----------------
    logic        m_busy, m_done, m_dz, m_res_dz;
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_res;
    int          m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0; m_res_dz = 1'b0;
            m_hi = '0; m_lo = '0; m_res = '0; m_left = 0;
        end else if (m_done) begin
            m_done = 1'b0;
            m_busy = 1'b0;
        end else if (m_busy) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                {m_hi, m_lo} = m_res;
                m_dz   = m_res_dz;
                m_done = 1'b1;
            end
        end else begin
            if (hi_we) m_hi = wdata;
            if (lo_we) m_lo = wdata;
            if (start) begin
                m_res    = ref_res(op, a, b);
                m_res_dz = op[1] && (b == 32'd0);
                m_dz     = 1'b0;
                m_busy   = 1'b1;
                m_left   = XLEN + 2;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("cyc_busy", 64'(busy), 64'(m_busy));
                check("cyc_done", 64'(done), 64'(m_done));
                check("cyc_hi", 64'(hi), 64'(m_hi));
                check("cyc_lo", 64'(lo), 64'(m_lo));
`ifdef MULDIV_DIVZERO_FLAG_EN
                check("cyc_dz", 64'(div_by_zero), 64'(m_dz));
`endif
            end
        end
    endtask

    // All stimulus changes 1ns after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin step(); n++; end
        if (busy) check("idle_timeout", 64'(busy), 64'd0);
    endtask

    // Issue one op, return cycles from accept edge to done (0 on timeout).
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, output int lat);
        int n = 0;
        wait_idle();
        start = 1'b1; op = o; a = x; b = y;
        step();
        start = 1'b0;
        while (!done && n < 100) begin step(); n++; end
        if (!done) begin
            check("done_timeout", 64'(done), 64'd1);
            n = 0;
        end
        lat = n;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 8)
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic [1:0]  o;
        logic [31:0] x, y, eh, el;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int lat, pulses;
        vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
        vecs[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
        vecs[5] = '{2'b11, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
        vecs[6] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
        vecs[7] = '{2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};

        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        fork
            compare_loop();
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        rst_n = 1'b1;
        step();

        // Directed literal cases: pin the model, the latency and the DUT result.
        foreach (vecs[i]) begin
            check($sformatf("model_%0d", i), ref_res(vecs[i].o, vecs[i].x, vecs[i].y), {vecs[i].eh, vecs[i].el});
            run_op(vecs[i].o, vecs[i].x, vecs[i].y, lat);
            check($sformatf("lat_%0d", i), 64'(lat), 64'(XLEN + 2));
            check($sformatf("hi_%0d", i), 64'(hi), 64'(vecs[i].eh));
            check($sformatf("lo_%0d", i), 64'(lo), 64'(vecs[i].el));
`ifdef MULDIV_DIVZERO_FLAG_EN
            check($sformatf("dz_%0d", i), 64'(div_by_zero), 64'(vecs[i].o[1] && vecs[i].y == 32'd0));
`endif
            $display("dir %0d op=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d", i, vecs[i].o, vecs[i].x, vecs[i].y, hi, lo, lat);
        end

        // Start and MTHI/MTLO in the same idle cycle: write lands, result overwrites.
        wait_idle();
        start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd5;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_1234;
        step();
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        check("same_cyc_hi", 64'(hi), 64'h1234);
        check("same_cyc_lo", 64'(lo), 64'h1234);
        check("same_cyc_busy", 64'(busy), 64'd1);
        wait_idle();
        check("same_cyc_res", {32'(hi), 32'(lo)}, 64'd15);
        $display("same-cycle write+start -> hi=%h lo=%h", hi, lo);

        // Second start and an MTLO at T+5 are both ignored; done pulses once.
        start = 1'b1; op = 2'b01; a = 32'd1000; b = 32'd3;
        step();
        start = 1'b0;
        repeat (4) step();
        start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd3; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
        step();
        start = 1'b0; lo_we = 1'b0;
        check("ignored_lo", 64'(lo), 64'd15);
        pulses = 0;
        repeat (45) begin step(); if (done) pulses++; end
        check("one_done", 64'(pulses), 64'd1);
        check("ignored_res", {32'(hi), 32'(lo)}, 64'd3000);
        $display("busy start/write ignored -> done pulses=%0d lo=%0d", pulses, lo);

        // Asynchronous reset mid-CALC discards the op.
        start = 1'b1; op = 2'b01; a = 32'hFFFF_FFFF; b = 32'd2;
        step();
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        step();
        rst_n = 1'b1;
        pulses = 0;
        repeat (40) begin step(); if (done) pulses++; end
        check("midrst_no_done", 64'(pulses), 64'd0);
        run_op(2'b01, 32'd3, 32'd4, lat);
        check("post_rst_lo", 64'(lo), 64'd12);
        check("post_rst_hi", 64'(hi), 64'd0);
        $display("mid-op reset -> no done; fresh 3*4 lo=%0d", lo);

        // Randomised traffic, checked every cycle by the compare loop.
        for (int c = 0; c < 3000; c++) begin
            start = ($urandom % 6) == 0;
            op    = 2'($urandom);
            a     = pick();
            b     = pick();
            hi_we = ($urandom % 8) == 0;
            lo_we = ($urandom % 8) == 0;
            wdata = $urandom;
            step();
            if (done)
                $display("rand done @%0t hi=%h lo=%h (model %h %h)", $time, hi, lo, m_hi, m_lo);
        end
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        wait_idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
